// File: rtl/uart_mem_pkg.sv
// uart_mem_pkg: shared states, response bytes and default opcodes for uart_mem_ctrl
package uart_mem_pkg;
  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, GET_CSUM, MEM, SEND, WAIT_TX} state_t;
  localparam logic [7:0] RESP_ACK = 8'h06;
  localparam logic [7:0] RESP_NAK = 8'h15;
  localparam logic [7:0] OP_WRITE_DEF = 8'h57;
  localparam logic [7:0] OP_READ_DEF = 8'h52;
  localparam int TIMEOUT_DEF = 4095;
endpackage

// File: rtl/uart_mem_timeout.sv
// uart_mem_timeout: saturating inter-byte idle counter (clk, rst, clr, en in; expire pulse out)
module uart_mem_timeout #(
  parameter int TIMEOUT = 4095
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  logic at_max;
  always_comb begin
    at_max = cnt_q == W'(TIMEOUT);
    cnt_d = clr ? '0 : (en && !at_max) ? cnt_q + W'(1) : cnt_q;
    expire = en && !clr && at_max;
  end
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/uart_mem_ctrl.sv
// uart_mem_ctrl: UART command packets to one memory read/write with a one-byte reply; checksum byte when UART_MEM_CTRL_CHECKSUM_EN is defined
module uart_mem_ctrl
  import uart_mem_pkg::*;
#(
  parameter int FRAME_WIDTH = 8,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter logic [FRAME_WIDTH-1:0] OP_WRITE = FRAME_WIDTH'(OP_WRITE_DEF),
  parameter logic [FRAME_WIDTH-1:0] OP_READ = FRAME_WIDTH'(OP_READ_DEF)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FRAME_WIDTH-1:0] rx_data,
  input  logic                   rx_done,
  output logic                   clr_rx_done,
  output logic [FRAME_WIDTH-1:0] tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [FRAME_WIDTH-1:0] mem_addr,
  output logic [FRAME_WIDTH-1:0] mem_wdata,
  input  logic [FRAME_WIDTH-1:0] mem_rdata,
  input  logic                   mem_ack,
  output logic                   err_timeout,
  output logic                   busy
);
  localparam logic [FRAME_WIDTH-1:0] ACK = FRAME_WIDTH'(RESP_ACK);
  localparam logic [FRAME_WIDTH-1:0] NAK = FRAME_WIDTH'(RESP_NAK);
`ifdef UART_MEM_CTRL_CHECKSUM_EN
  localparam state_t PAYLOAD_END = GET_CSUM;
  logic [FRAME_WIDTH-1:0] csum_q, csum_d;
`else
  localparam state_t PAYLOAD_END = MEM;
`endif
  state_t state_q, state_d;
  logic op_we_q, op_we_d, tx_seen_q, tx_seen_d;
  logic clr_rx_done_q, clr_rx_done_d, tx_start_q, tx_start_d;
  logic mem_req_q, mem_req_d, mem_we_q, mem_we_d, err_timeout_q, err_timeout_d;
  logic [FRAME_WIDTH-1:0] tx_data_q, tx_data_d, mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic accept, tmo_en, expire;
  assign accept = rx_done && !clr_rx_done_q && (state_q inside {IDLE, GET_ADDR, GET_DATA, GET_CSUM});
  assign tmo_en = state_q inside {GET_ADDR, GET_DATA, GET_CSUM};
  uart_mem_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk(clk), .rst(rst), .clr(accept), .en(tmo_en), .expire(expire)
  );
  always_comb begin
    state_d = state_q;
    op_we_d = op_we_q;
    tx_seen_d = tx_seen_q;
    tx_data_d = tx_data_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_req_d = mem_req_q;
    mem_we_d = mem_we_q;
    clr_rx_done_d = accept;
    tx_start_d = 1'b0;
    err_timeout_d = 1'b0;
`ifdef UART_MEM_CTRL_CHECKSUM_EN
    csum_d = !accept ? csum_q : state_q == IDLE ? rx_data : csum_q ^ rx_data;
`endif
    if (expire) begin
      state_d = IDLE;
      err_timeout_d = 1'b1;
    end else case (state_q)
      IDLE: if (accept) begin
        state_d = (rx_data == OP_WRITE || rx_data == OP_READ) ? GET_ADDR : SEND;
        op_we_d = rx_data == OP_WRITE;
        tx_data_d = (rx_data == OP_WRITE || rx_data == OP_READ) ? tx_data_q : NAK;
      end
      GET_ADDR: if (accept) begin
        mem_addr_d = rx_data;
        state_d = op_we_q ? GET_DATA : PAYLOAD_END;
      end
      GET_DATA: if (accept) begin
        mem_wdata_d = rx_data;
        state_d = PAYLOAD_END;
      end
      GET_CSUM: begin
`ifdef UART_MEM_CTRL_CHECKSUM_EN
        if (accept) begin
          state_d = rx_data == csum_q ? MEM : SEND;
          tx_data_d = rx_data == csum_q ? tx_data_q : NAK;
        end
`else
        state_d = IDLE;
`endif
      end
      MEM: if (mem_ack) begin
        mem_req_d = 1'b0;
        tx_data_d = op_we_q ? ACK : mem_rdata;
        state_d = tx_busy ? SEND : WAIT_TX;
        tx_start_d = !tx_busy;
        tx_seen_d = 1'b0;
      end
      SEND: if (!tx_busy) begin
        tx_start_d = 1'b1;
        state_d = WAIT_TX;
        tx_seen_d = 1'b0;
      end
      WAIT_TX: begin
        tx_seen_d = tx_seen_q | tx_busy;
        state_d = (tx_seen_q && !tx_busy) ? IDLE : WAIT_TX;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == MEM && state_q != MEM) begin
      mem_req_d = 1'b1;
      mem_we_d = op_we_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_we_q <= 1'b0;
      tx_seen_q <= 1'b0;
      tx_data_q <= '0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      mem_req_q <= 1'b0;
      mem_we_q <= 1'b0;
      clr_rx_done_q <= 1'b0;
      tx_start_q <= 1'b0;
      err_timeout_q <= 1'b0;
`ifdef UART_MEM_CTRL_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_we_q <= op_we_d;
      tx_seen_q <= tx_seen_d;
      tx_data_q <= tx_data_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_req_q <= mem_req_d;
      mem_we_q <= mem_we_d;
      clr_rx_done_q <= clr_rx_done_d;
      tx_start_q <= tx_start_d;
      err_timeout_q <= err_timeout_d;
`ifdef UART_MEM_CTRL_CHECKSUM_EN
      csum_q <= csum_d;
`endif
    end
  end
  assign clr_rx_done = clr_rx_done_q;
  assign tx_data = tx_data_q;
  assign tx_start = tx_start_q;
  assign mem_req = mem_req_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err_timeout = err_timeout_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_uart_mem_ctrl.sv
// tb_uart_mem_ctrl: scoreboard bench with a transaction-level model of uart_mem_ctrl
module tb_uart_mem_ctrl;
  localparam int TMO = 60;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic rx_done = 1'b0;
  logic clr_rx_done, tx_start, mem_req, mem_we, err_timeout, busy;
  logic [7:0] tx_data, mem_addr, mem_wdata;
  logic tx_busy = 1'b0;
  logic [7:0] mem_rdata = '0;
  logic resp_ack = 1'b0;
  logic late_ack = 1'b0;
  bit auto_mem = 1'b1;
  int errors = 0, checks = 0;
  int tx_cnt = 0, clr_cnt = 0, to_cnt = 0, sent = 0;
  logic [7:0] ref_mem [256];
  logic [7:0] tx_q [$];
  logic [16:0] mem_q [$];

  uart_mem_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .clr_rx_done(clr_rx_done),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(resp_ack | late_ack),
    .err_timeout(err_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [7:0] mem_arr [256];
    int d = 0;
    for (int a = 0; a < 256; a++) mem_arr[a] = 8'(a) ^ 8'h3C;
    forever begin
      @(posedge clk); #1;
      resp_ack = 1'b0;
      mem_rdata = 8'($urandom);
      if (auto_mem && mem_req) begin
        if (d == 0) begin
          resp_ack = 1'b1;
          mem_rdata = mem_arr[mem_addr];
          if (mem_we) mem_arr[mem_addr] = mem_wdata;
          d = $urandom_range(0, 3);
        end else d--;
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (tx_start) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1 tx_busy = 1'b1;
      repeat ($urandom_range(2, 5)) @(posedge clk);
      #1 tx_busy = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (clr_rx_done) clr_cnt++;
    if (err_timeout) to_cnt++;
    if (!rst && tx_start) begin
      tx_cnt++;
      chk(tx_q.size() != 0, "unexpected_tx_start", int'(tx_data), 0);
      if (tx_q.size() != 0) begin
        logic [7:0] e;
        e = tx_q.pop_front();
        chk(tx_data == e, "tx_data", int'(tx_data), int'(e));
      end
    end
  end

  initial begin
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req && !prev) begin
        logic [16:0] got;
        got = {mem_we, mem_addr, mem_we ? mem_wdata : 8'h00};
        chk(mem_q.size() != 0, "unexpected_mem_req", int'(got), 0);
        if (mem_q.size() != 0) begin
          logic [16:0] e;
          e = mem_q.pop_front();
          chk(got == e, "mem_op", int'(got), int'(e));
        end
      end
      prev = mem_req;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    rx_data = b;
    rx_done = 1'b1;
    sent++;
    for (int i = 0; i < 5000 && !got; i++) begin
      @(negedge clk);
      got = clr_rx_done;
    end
    chk(got, "rx_accept", int'(got), 1);
    @(posedge clk); #1 rx_done = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] b0, b1, b2, input int n, input bit bad_cs, input int gap);
    logic [7:0] b [3];
    logic [7:0] x;
    b[0] = b0; b[1] = b1; b[2] = b2;
    x = bad_cs ? 8'hFF : 8'h00;
    for (int i = 0; i < n; i++) begin
      send_byte(b[i]);
      x ^= b[i];
      repeat (gap < 0 ? $urandom_range(0, 3) : gap) @(posedge clk);
      #1;
    end
`ifdef UART_MEM_CTRL_CHECKSUM_EN
    if (n > 1) send_byte(x);
`endif
  endtask

  task automatic do_write(input logic [7:0] a, d, input int gap);
    mem_q.push_back({1'b1, a, d});
    tx_q.push_back(8'h06);
    ref_mem[a] = d;
    send_pkt(8'h57, a, d, 3, 1'b0, gap);
  endtask

  task automatic do_read(input logic [7:0] a);
    mem_q.push_back({1'b0, a, 8'h00});
    tx_q.push_back(ref_mem[a]);
    send_pkt(8'h52, a, 8'h00, 2, 1'b0, -1);
  endtask

  task automatic do_bad(input logic [7:0] op);
    tx_q.push_back(8'h15);
    send_pkt(op, 8'h00, 8'h00, 1, 1'b0, -1);
  endtask

  task automatic drain(input string name);
    int i = 0;
    while ((tx_q.size() != 0 || mem_q.size() != 0 || busy) && i < 3000) begin
      @(negedge clk);
      i++;
    end
    chk(tx_q.size() == 0 && mem_q.size() == 0 && !busy, name, tx_q.size() + mem_q.size(), 0);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) ref_mem[a] = 8'(a) ^ 8'h3C;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({clr_rx_done, tx_start, mem_req, mem_we, err_timeout, busy} == 6'b0, "reset_ctrl",
        int'({clr_rx_done, tx_start, mem_req, mem_we, err_timeout, busy}), 0);
    chk(tx_data == 8'h00, "reset_tx_data", int'(tx_data), 0);
    chk(mem_addr == 8'h00, "reset_mem_addr", int'(mem_addr), 0);
    chk(mem_wdata == 8'h00, "reset_mem_wdata", int'(mem_wdata), 0);
    @(posedge clk); #1 rst = 1'b0;

    do_write(8'h10, 8'hA5, -1);
    drain("write_drain");
    chk(tx_data == 8'h06, "write_ack_held", int'(tx_data), 8'h06);
    chk(mem_addr == 8'h10 && mem_wdata == 8'hA5, "write_regs_held", int'({mem_addr, mem_wdata}), 16'h10A5);
    do_read(8'h10);
    drain("read_drain");
    chk(tx_data == 8'hA5, "read_data_held", int'(tx_data), 8'hA5);
    chk(clr_cnt == sent, "clr_rx_done_count", clr_cnt, sent);
    chk(tx_cnt == 2, "tx_start_count", tx_cnt, 2);
    do_bad(8'h33);
    drain("bad_op_drain");
    chk(tx_data == 8'h15, "nak_held", int'(tx_data), 8'h15);
    chk(mem_addr == 8'h10, "addr_held_after_nak", int'(mem_addr), 8'h10);

`ifdef UART_MEM_CTRL_CHECKSUM_EN
    do_write(8'h01, 8'h02, -1);
    drain("csum_good_drain");
    tx_q.push_back(8'h15);
    send_pkt(8'h57, 8'h01, 8'h03, 3, 1'b1, -1);
    drain("csum_bad_drain");
    do_read(8'h01);
    drain("csum_read_drain");
`endif

    begin
      int tc, to0;
      tc = tx_cnt;
      to0 = to_cnt;
      send_byte(8'h57);
      repeat (TMO + 20) @(negedge clk);
      chk(to_cnt - to0 == 1, "timeout_pulses", to_cnt - to0, 1);
      chk(!busy, "timeout_idle", int'(busy), 0);
      chk(tx_cnt == tc, "timeout_no_tx", tx_cnt, tc);
      @(posedge clk); #1;
      do_read(8'h00);
      drain("after_timeout_drain");
    end

    do_write(8'h44, 8'h99, TMO - 10);
    drain("slow_write_drain");
    chk(to_cnt == 1, "slow_no_timeout", to_cnt, 1);

    begin
      int tc;
      bit seen = 1'b0;
      auto_mem = 1'b0;
      mem_q.push_back({1'b1, 8'h20, 8'h77});
      send_pkt(8'h57, 8'h20, 8'h77, 3, 1'b0, -1);
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        seen = mem_req;
      end
      chk(seen, "mem_req_seen", int'(seen), 1);
      repeat (5) @(negedge clk);
      chk(mem_req && mem_we, "mem_req_held", int'({mem_req, mem_we}), 3);
      tc = tx_cnt;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk({mem_req, busy} == 2'b00, "reset_mid_mem", int'({mem_req, busy}), 0);
      chk(mem_addr == 8'h00 && tx_data == 8'h00, "reset_mid_regs", int'({mem_addr, tx_data}), 0);
      @(posedge clk); #1 late_ack = 1'b1;
      @(posedge clk); #1 late_ack = 1'b0;
      repeat (20) @(negedge clk);
      chk(tx_cnt == tc, "late_ack_no_tx", tx_cnt, tc);
      chk(!busy, "late_ack_idle", int'(busy), 0);
      auto_mem = 1'b1;
    end

    for (int i = 0; i < 40; i++) begin
      int r;
      logic [7:0] op;
      r = $urandom_range(0, 9);
      if (r < 4) do_write(8'($urandom_range(0, 7)), 8'($urandom), -1);
      else if (r < 7) do_read(8'($urandom_range(0, 7)));
      else if (r == 7) begin
        do op = 8'($urandom); while (op == 8'h57 || op == 8'h52);
        do_bad(op);
      end else begin
`ifdef UART_MEM_CTRL_CHECKSUM_EN
        tx_q.push_back(8'h15);
        send_pkt(8'h57, 8'($urandom_range(0, 7)), 8'($urandom), 3, 1'b1, -1);
`else
        do_write(8'($urandom_range(0, 7)), 8'($urandom), -1);
`endif
      end
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
    end
    drain("random_drain");
    chk(clr_cnt == sent, "final_clr_count", clr_cnt, sent);
    chk(to_cnt == 1, "final_timeout_count", to_cnt, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_mem_ctrl.md
Name: uart_mem_ctrl

Overview:
- Command sequencer between the UART receive/transmit datapaths and a simple synchronous memory port.
- Collects bytes from the UART receiver into command packets, performs a single memory read or write, and returns a one-byte response through the UART transmitter.
- Sits between the UART rx/tx pair and the memory model in the UART-memory example top level.

Parameters:
- FRAME_WIDTH, 8, UART data bits per frame; also the width of addr, data and response bytes.
- TIMEOUT, 4095, max idle clk cycles between bytes of one packet before the packet is aborted.
- OP_WRITE, 8'h57, opcode byte for write ('W').
- OP_READ, 8'h52, opcode byte for read ('R').

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- rx_data  input  FRAME_WIDTH  received byte from UART receiver
- rx_done  input  1  receiver holds a valid byte
- clr_rx_done  output  1  registered one-cycle pulse acknowledging rx byte
- tx_data  output  FRAME_WIDTH  byte to transmit; held stable until tx_busy falls
- tx_start  output  1  one-cycle pulse launching transmission
- tx_busy  input  1  transmitter shifting
- mem_req  output  1  memory request, held until mem_ack
- mem_we  output  1  1=write, 0=read; valid with mem_req
- mem_addr  output  FRAME_WIDTH  memory address
- mem_wdata  output  FRAME_WIDTH  write data
- mem_rdata  input  FRAME_WIDTH  read data, valid in the cycle mem_ack=1
- mem_ack  input  1  one-cycle completion pulse
- err_timeout  output  1  one-cycle pulse on packet abort
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, active-high; applies at any state, including mid-packet):
  - state=IDLE; clr_rx_done, tx_start, mem_req, mem_we, err_timeout all 0.
  - tx_data, mem_addr, mem_wdata = 0; timeout counter = 0.
  - A pending mem_ack or tx_busy is ignored after reset.
- Byte accept rule: a byte is accepted in cycle t when rx_done=1 and clr_rx_done=0. clr_rx_done=1 in t+1; rx_done is ignored while clr_rx_done=1. This prevents double capture while the receiver's flag is still set.
- Packet formats:
  - Write: OP, ADDR, DATA.
  - Read: OP, ADDR.
- State machine:
  - IDLE: accepted byte == OP_WRITE or OP_READ -> GET_ADDR, latch opcode. Any other byte -> SEND with tx_data=8'h15 (NAK).
  - GET_ADDR: accepted byte -> mem_addr. Write -> GET_DATA; read -> MEM.
  - GET_DATA: accepted byte -> mem_wdata -> MEM.
  - MEM: mem_req=1, mem_we per opcode. On mem_ack, mem_req falls the next cycle.
    - Write: tx_data=8'h06 (ACK).
    - Read: tx_data=mem_rdata, captured in the ack cycle.
    - Then -> SEND.
  - SEND: if tx_busy=0, pulse tx_start for one cycle -> WAIT_TX; otherwise stay.
  - WAIT_TX: waits for tx_busy to rise and then fall (2-flag tracking) -> IDLE.
- Latency: last rx byte accepted at t -> mem_req at t+1. mem_ack at a -> tx_start at a+1 minimum.
- Timeout:
  - Counter is active only in GET_ADDR/GET_DATA. It clears on every accepted byte and on entering those states.
  - When it reaches TIMEOUT: pulse err_timeout, go to IDLE, send no response.
  - Counter width is $clog2(TIMEOUT+1) and saturates; no wrap.
- Bytes arriving during MEM/SEND/WAIT_TX are not accepted; clr_rx_done stays 0 and the receiver's rx_done remains set. That byte is consumed as the first byte of the next packet once IDLE.
- mem_ack outside MEM is ignored.
- tx_data, mem_addr and mem_wdata hold their values between transactions.

Optional Feature:
- Macro: UART_MEM_CTRL_CHECKSUM_EN.
- Defined:
  - A state GET_CSUM follows the last payload byte; its byte must equal the XOR of all prior packet bytes.
  - Mismatch -> SEND NAK (8'h15), no memory access.
  - The timeout also covers GET_CSUM.
- Undefined: no checksum byte, state and XOR register absent; behaviour as above.

Decomposition:
- Package uart_mem_pkg:
  - state_t enum: IDLE, GET_ADDR, GET_DATA, GET_CSUM, MEM, SEND, WAIT_TX. GET_CSUM is always present in the enum and unreachable when the macro is undefined.
  - Constants RESP_ACK=8'h06 and RESP_NAK=8'h15.
  - Default opcode constants.
- One sub-module is natural: uart_mem_timeout, a saturating inter-byte counter with clear/enable inputs and an expire pulse output.

Test Plan:
- Write: bytes 57,10,A5 -> mem_req, mem_we=1, mem_addr=10, mem_wdata=A5; ack -> tx_data=06, single tx_start.
- Read: after the write above, bytes 52,10; mem_rdata=A5 on ack -> tx_data=A5, exactly one clr_rx_done per byte (3+2 total).
- Bad opcode: byte 33 -> tx_data=15, tx_start pulse, mem_req never asserts.
- Timeout: byte 57 then no byte for TIMEOUT cycles -> err_timeout one pulse, busy=0, no tx_start; next 52,00 is processed normally.
- Reset mid-MEM with mem_req=1: rst for one cycle -> mem_req=0, state IDLE next cycle; late mem_ack produces no tx_start.
- Checksum (macro defined): 57,01,02,54 -> write performed, ACK. With 57,01,02,00 -> NAK, no mem_req.
